fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/rv_pkg.sv | 45 ++++
 rtl/fetch_decode_if.sv | 40 ++++
 rtl/fetch_decode_opcode_decode.sv | 27 ++
 rtl/fetch_decode.sv | 118 +++++++++++
 tb/tb_fetch_decode.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, FSM states, NOP word and decode flags.
package rv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned STATE_W = 2;

    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fd_state_e;

    // Plain-vector views of the state encoding for the FSM register.
    localparam logic [STATE_W-1:0] ST_IDLE  = STATE_W'(S_IDLE);
    localparam logic [STATE_W-1:0] ST_REQ   = STATE_W'(S_REQ);
    localparam logic [STATE_W-1:0] ST_ISSUE = STATE_W'(S_ISSUE);
    localparam logic [STATE_W-1:0] ST_HALT  = STATE_W'(S_HALT);

    typedef struct packed {
        logic r_type;
        logic i_type;
        logic store;
        logic branch;
        logic load;
        logic jal;
        logic jalr;
        logic auipc;
        logic lui;
    } dec_flags_t;

endpackage

// File: rtl/fetch_decode_if.sv
// Instruction-memory, retire/redirect and decoded-instruction signals of the fetch/decode stage.
interface fetch_decode_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic            retire;
    logic            br_taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            r_type;
    logic            i_type;
    logic            store;
    logic            branch;
    logic            load;
    logic            jal;
    logic            jalr;
    logic            auipc;
    logic            lui;
    logic            illegal;
    logic            trap;

    modport master (
        output imem_req, imem_addr, pc_out, instr, instr_valid,
               r_type, i_type, store, branch, load, jal, jalr, auipc, lui,
               illegal, trap,
        input  imem_ready, imem_rdata, retire, br_taken, target
    );

    modport slave (
        input  imem_req, imem_addr, pc_out, instr, instr_valid,
               r_type, i_type, store, branch, load, jal, jalr, auipc, lui,
               illegal, trap,
        output imem_ready, imem_rdata, retire, br_taken, target
    );
endinterface

// File: rtl/fetch_decode_opcode_decode.sv
// Combinational opcode classifier: instr[6:0] to one-hot class flags plus illegal.
module opcode_decode
    import rv_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output dec_flags_t      flags,
    output logic            illegal
);

    always_comb begin
        flags   = '0;
        illegal = 1'b0;
        case (opcode)
            OP_R:      flags.r_type = 1'b1;
            OP_I:      flags.i_type = 1'b1;
            OP_LOAD:   flags.load   = 1'b1;
            OP_STORE:  flags.store  = 1'b1;
            OP_BRANCH: flags.branch = 1'b1;
            OP_JAL:    flags.jal    = 1'b1;
            OP_JALR:   flags.jalr   = 1'b1;
            OP_AUIPC:  flags.auipc  = 1'b1;
            OP_LUI:    flags.lui    = 1'b1;
            default:   illegal      = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Single-outstanding fetch FSM with registered decode flags.
// Optional feature: define MISALIGN_TRAP_EN to halt with trap on a misaligned redirect.
module fetch_decode
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_decode_if.master bus
);

    logic [STATE_W-1:0] state, state_next;
    logic [XLEN-1:0]    pc, pc_next;
    logic [XLEN-1:0]    instr_q, instr_next;
    logic               imem_req_q;
    logic               valid_q;
    dec_flags_t         flags_q, dec_flags;
    logic               illegal_q, dec_illegal;
    logic [XLEN-1:0]    redirect_pc;

`ifdef MISALIGN_TRAP_EN
    logic               trap_q;
    logic               misaligned;
    assign misaligned  = (bus.target[1:0] != 2'b00);
    assign redirect_pc = bus.target;
`else
    logic               unused_target_lsb;
    assign unused_target_lsb = &{1'b0, bus.target[1:0]};
    assign redirect_pc       = {bus.target[XLEN-1:2], 2'b00};
`endif

    // Decode the word that will sit in instr next cycle so flags are registered alongside it.
    opcode_decode u_decode (
        .opcode  (instr_next[OP_W-1:0]),
        .flags   (dec_flags),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr_q;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (bus.imem_ready) begin
                    instr_next = bus.imem_rdata;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.retire) begin
                    state_next = ST_REQ;
                    if (bus.br_taken) begin
`ifdef MISALIGN_TRAP_EN
                        if (misaligned) state_next = ST_HALT;
                        else            pc_next    = redirect_pc;
`else
                        pc_next = redirect_pc;
`endif
                    end else begin
                        pc_next = pc + XLEN'(4);
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            instr_q    <= NOP;
            imem_req_q <= 1'b0;
            valid_q    <= 1'b0;
            flags_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_q    <= instr_next;
            imem_req_q <= (state_next == ST_REQ);
            valid_q    <= (state_next == ST_ISSUE);
            flags_q    <= (state_next == ST_ISSUE) ? dec_flags : '0;
            illegal_q  <= (state_next == ST_ISSUE) && dec_illegal;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= (state_next == ST_HALT);
    end
    assign bus.trap = trap_q;
`else
    assign bus.trap = 1'b0;
`endif

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc;
    assign bus.pc_out      = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.r_type      = flags_q.r_type;
    assign bus.i_type      = flags_q.i_type;
    assign bus.store       = flags_q.store;
    assign bus.branch      = flags_q.branch;
    assign bus.load        = flags_q.load;
    assign bus.jal         = flags_q.jal;
    assign bus.jalr        = flags_q.jalr;
    assign bus.auipc       = flags_q.auipc;
    assign bus.lui         = flags_q.lui;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode; honours MISALIGN_TRAP_EN when defined.
module tb_fetch_decode;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_decode_if bus ();

    fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] flag_vec();
        return {bus.r_type, bus.i_type, bus.store, bus.branch, bus.load,
                bus.jal, bus.jalr, bus.auipc, bus.lui};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Complete a fetch from REQ with the given word; leaves the stage in ISSUE.
    task automatic do_fetch(input logic [31:0] word);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        step();
        bus.imem_ready = 1'b0;
    endtask

    // Retire the held instruction; leaves the stage in REQ.
    task automatic do_retire(input logic br, input logic [31:0] tgt);
        bus.retire   = 1'b1;
        bus.br_taken = br;
        bus.target   = tgt;
        step();
        bus.retire   = 1'b0;
        bus.br_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.trap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b valid=%b trap=%b, expected 0 0 0",
                     bus.imem_req, bus.instr_valid, bus.trap);
        end
        n_tests++;
        if (bus.instr !== 32'h0000_0013 || bus.pc_out !== 32'h0 || flag_vec() !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_data: instr=%h pc=%h flags=%b, expected 00000013 0 0",
                     bus.instr, bus.pc_out, flag_vec());
        end
    endtask

    task automatic test_first_fetch();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_0033;
        rst = 1'b0;
        step();
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h, expected 1 00000000", bus.imem_req, bus.imem_addr);
        end
        step();
        bus.imem_ready = 1'b0;
        n_tests++;
        if (bus.instr_valid !== 1'b1 || bus.r_type !== 1'b1 || bus.imem_req !== 1'b0 ||
            bus.instr !== 32'h0000_0033) begin
            n_fail++;
            $display("FAIL first_issue: valid=%b r=%b req=%b instr=%h, expected 1 1 0 00000033",
                     bus.instr_valid, bus.r_type, bus.imem_req, bus.instr);
        end
    endtask

    task automatic test_retire();
        do_retire(1'b0, 32'hDEAD_BEE0);
        n_tests++;
        if (bus.imem_addr !== 32'h0000_0004 || bus.instr_valid !== 1'b0 || flag_vec() !== 9'h0) begin
            n_fail++;
            $display("FAIL seq_pc: addr=%h valid=%b flags=%b, expected 00000004 0 0",
                     bus.imem_addr, bus.instr_valid, flag_vec());
        end
        do_fetch(32'h0000_0013);
        do_retire(1'b1, 32'h0000_0100);
        n_tests++;
        if (bus.imem_addr !== 32'h0000_0100 || bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_pc: addr=%h req=%b, expected 00000100 1", bus.imem_addr, bus.imem_req);
        end
        // retire outside ISSUE must not move the PC
        bus.retire   = 1'b1;
        bus.br_taken = 1'b1;
        bus.target   = 32'h0000_0200;
        step();
        bus.retire   = 1'b0;
        bus.br_taken = 1'b0;
        n_tests++;
        if (bus.imem_addr !== 32'h0000_0100 || bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL retire_ignored: addr=%h req=%b, expected 00000100 1", bus.imem_addr, bus.imem_req);
        end
    endtask

    task automatic test_stall();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0100 || bus.instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: req=%b addr=%h valid=%b, expected 1 00000100 0",
                         i, bus.imem_req, bus.imem_addr, bus.instr_valid);
            end
        end
        do_fetch(32'h0000_0063);
        n_tests++;
        if (bus.instr_valid !== 1'b1 || bus.branch !== 1'b1 || bus.pc_out !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL stall_issue: valid=%b branch=%b pc=%h, expected 1 1 00000100",
                     bus.instr_valid, bus.branch, bus.pc_out);
        end
        bus.imem_rdata = 32'h0000_0037;
        step();
        step();
        n_tests++;
        if (bus.instr !== 32'h0000_0063 || bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
            flag_vec() !== 9'b0_0010_0000) begin
            n_fail++;
            $display("FAIL issue_hold: instr=%h valid=%b req=%b flags=%b, expected 00000063 1 0 000100000",
                     bus.instr, bus.instr_valid, bus.imem_req, flag_vec());
        end
    endtask

    task automatic test_wrap();
        do_retire(1'b1, 32'hFFFF_FFFC);
        n_tests++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_redirect: addr=%h, expected fffffffc", bus.imem_addr);
        end
        do_fetch(32'h0000_0013);
        do_retire(1'b0, 32'h0);
        n_tests++;
        if (bus.imem_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_pc: addr=%h, expected 00000000", bus.imem_addr);
        end
    endtask

    task automatic test_opcodes();
        logic [31:0] words [10];
        logic [8:0]  exp_f [10];
        words = '{32'h0000_0033, 32'h0000_0013, 32'h0000_0023, 32'h0000_0063, 32'h0000_0003,
                  32'h0000_006F, 32'h0000_0067, 32'h0000_0017, 32'h0000_0037, 32'h0000_007F};
        exp_f = '{9'b1_0000_0000, 9'b0_1000_0000, 9'b0_0100_0000, 9'b0_0010_0000, 9'b0_0001_0000,
                  9'b0_0000_1000, 9'b0_0000_0100, 9'b0_0000_0010, 9'b0_0000_0001, 9'b0_0000_0000};
        for (int i = 0; i < 10; i++) begin
            do_fetch(words[i]);
            n_tests++;
            if (flag_vec() !== exp_f[i] || bus.illegal !== (i == 9) || bus.instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL opcode_%h: flags=%b illegal=%b valid=%b, expected %b %b 1",
                         words[i], flag_vec(), bus.illegal, bus.instr_valid, exp_f[i], (i == 9));
            end
            do_retire(1'b0, 32'h0);
        end
        n_tests++;
        if (bus.illegal !== 1'b0 || bus.imem_addr !== 32'h0000_0028) begin
            n_fail++;
            $display("FAIL illegal_retired: illegal=%b addr=%h, expected 0 00000028",
                     bus.illegal, bus.imem_addr);
        end
    endtask

    task automatic test_reset_in_req();
        bus.imem_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_tests++;
        if (bus.imem_req !== 1'b0 || bus.pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_abandon: req=%b pc=%h, expected 0 00000000", bus.imem_req, bus.pc_out);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_refetch: req=%b addr=%h, expected 1 00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_misalign();
        do_fetch(32'h0000_006F);
        do_retire(1'b1, 32'h0000_0102);
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.trap !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
                bus.pc_out !== 32'h0) begin
                n_fail++;
                $display("FAIL halt_%0d: trap=%b req=%b valid=%b pc=%h, expected 1 0 0 00000000",
                         i, bus.trap, bus.imem_req, bus.instr_valid, bus.pc_out);
            end
            bus.imem_ready = 1'b1;
            step();
        end
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (bus.trap !== 1'b0 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: trap=%b req=%b, expected 0 0", bus.trap, bus.imem_req);
        end
`else
        n_tests++;
        if (bus.imem_addr !== 32'h0000_0100 || bus.imem_req !== 1'b1 || bus.trap !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_forced: addr=%h req=%b trap=%b, expected 00000100 1 0",
                     bus.imem_addr, bus.imem_req, bus.trap);
        end
`endif
    endtask

    initial begin
        rst            = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.retire     = 1'b0;
        bus.br_taken   = 1'b0;
        bus.target     = 32'h0;
        test_reset();
        test_first_fetch();
        test_retire();
        test_stall();
        test_wrap();
        test_opcodes();
        test_reset_in_req();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
